// File: rtl/multdiv_seq.sv
// multdiv_seq: sequential signed 32-bit radix-2 Booth multiplier and restoring divider.
// The divider datapath is built only when MULTDIV_DIVIDER_EN is defined; otherwise ctrl_DIV reports an exception.
`default_nettype none

module multdiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] acc, q, m;
  logic        q1;
  logic [4:0]  cnt;
  logic [31:0] acc_nx, q_nx;
  logic        q1_nx;
  logic [32:0] mul_sum;
  logic [31:0] res_nx;
  logic        exc_nx;
  logic        start_mul, start_div, iter_last;

`ifdef MULTDIV_DIVIDER_EN
  logic        neg, dz;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [31:0] quot, abs_a, abs_b;

  assign abs_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign abs_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
`endif

  // Multiply wins when both starts arrive together.
  assign start_mul = ctrl_MULT;
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign iter_last = (cnt == 5'd31);
  assign busy      = (state == MUL) || (state == DIV);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start_mul) begin
      state_nx = MUL;
    end else if (start_div) begin
`ifdef MULTDIV_DIVIDER_EN
      state_nx = DIV;
`else
      state_nx = DONE;
`endif
    end else begin
      case (state)
        IDLE:     state_nx = IDLE;
        MUL, DIV: if (iter_last) state_nx = DONE;
        DONE:     state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  // One iteration step. The Booth adder is one bit wider than A so that
  // adding or subtracting 0x80000000 cannot wrap before the arithmetic shift.
  always_comb begin
    case ({q[0], q1})
      2'b01:   mul_sum = {acc[31], acc} + {m[31], m};
      2'b10:   mul_sum = {acc[31], acc} - {m[31], m};
      default: mul_sum = {acc[31], acc};
    endcase
    acc_nx = mul_sum[32:1];
    q_nx   = {mul_sum[0], q[31:1]};
    q1_nx  = q[0];
`ifdef MULTDIV_DIVIDER_EN
    div_shift = {acc, q[31]};
    div_diff  = div_shift - {1'b0, m};
    div_ge    = ~div_diff[32];
    if (state == DIV) begin
      acc_nx = div_ge ? div_diff[31:0] : div_shift[31:0];
      q_nx   = {q[30:0], div_ge};
      q1_nx  = 1'b0;
    end
`endif
  end

  // Final result is formed from the last step's outputs, so it lands on DONE entry.
  always_comb begin
    res_nx = q_nx;
    exc_nx = ~((&{acc_nx, q_nx[31]}) | ~(|{acc_nx, q_nx[31]}));
`ifdef MULTDIV_DIVIDER_EN
    quot = neg ? (32'd0 - q_nx) : q_nx;
    if (state == DIV) begin
      res_nx = dz ? 32'd0 : quot;
      exc_nx = dz | (~neg & q_nx[31]);
    end
`else
    if (start_div) begin
      res_nx = 32'd0;
      exc_nx = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc            <= '0;
      q              <= '0;
      m              <= '0;
      q1             <= 1'b0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef MULTDIV_DIVIDER_EN
      neg            <= 1'b0;
      dz             <= 1'b0;
`endif
    end else begin
      data_resultRDY <= (state == DONE);
      if (state_nx == DONE) begin
        data_result    <= res_nx;
        data_exception <= exc_nx;
      end
      if (start_mul) begin
        acc <= '0;
        q   <= data_operandB;
        q1  <= 1'b0;
        m   <= data_operandA;
        cnt <= '0;
      end
`ifdef MULTDIV_DIVIDER_EN
      else if (start_div) begin
        acc <= '0;
        q   <= abs_a;
        q1  <= 1'b0;
        m   <= abs_b;
        neg <= data_operandA[31] ^ data_operandB[31];
        dz  <= (data_operandB == 32'd0);
        cnt <= '0;
      end
`endif
      else if (busy) begin
        acc <= acc_nx;
        q   <= q_nx;
        q1  <= q1_nx;
        cnt <= cnt + 5'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed scenarios plus randomized traffic checked every cycle against a
// cycle-count/arithmetic model of multdiv_seq.
`default_nettype none

module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV  = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_seen = 0;

`ifdef MULTDIV_DIVIDER_EN
  localparam int DIV_LAT = 33;
  localparam bit HAS_DIV = 1'b1;
`else
  localparam int DIV_LAT = 1;
  localparam bit HAS_DIV = 1'b0;
`endif

  always #5 clock = ~clock;

  multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Arithmetic reference: returns {exception, result}.
  function automatic logic [32:0] ref_op(bit is_mul, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] p;
    int sa, sb;
    if (is_mul) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return {({{32{p[31]}}, p[31:0]} != p), p[31:0]};
    end
    if (!HAS_DIV || b == 32'd0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    sa = a;
    sb = b;
    return {1'b0, 32'(sa / sb)};
  endfunction

  // Behavioural model: an operation completes a fixed number of edges after its start edge;
  // results appear one edge before the ready pulse and hold until the next completion.
  bit          m_active = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_res_pend = '0;
  logic        m_exc_pend = 1'b0;
  logic [31:0] exp_result = '0;
  logic        exp_exc = 1'b0;
  logic        exp_rdy = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active   = 1'b0;
      m_rem      = 0;
      exp_result = '0;
      exp_exc    = 1'b0;
      exp_rdy    = 1'b0;
    end else begin
      exp_rdy = 1'b0;
      if (m_active) begin
        m_rem--;
        if (m_rem == 0) begin
          exp_rdy  = 1'b1;
          m_active = 1'b0;
        end
      end
      if (ctrl_MULT || ctrl_DIV) begin
        {m_exc_pend, m_res_pend} = ref_op(ctrl_MULT, data_operandA, data_operandB);
        m_active = 1'b1;
        m_rem    = ctrl_MULT ? 33 : DIV_LAT;
      end
      if (m_active && m_rem == 1) begin
        exp_result = m_res_pend;
        exp_exc    = m_exc_pend;
      end
    end
  end

  always @(negedge clock) begin
    check("rdy", data_resultRDY, exp_rdy);
    check("busy", busy, (m_active && m_rem >= 2));
    check("result", data_result, exp_result);
    check("exception", data_exception, exp_exc);
    if (data_resultRDY) rdy_seen++;
  end

  task automatic pulse(bit mul, bit div, logic [31:0] a, logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called at the negedge right after the start edge; lat counts negedges until ready.
  task automatic wait_rdy(int max, output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!data_resultRDY && lat < max) begin
      if (busy) busy_n++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic directed(string name, bit mul, bit div, logic [31:0] a, logic [31:0] b,
                          logic [31:0] e_res, logic e_exc, int e_lat, int e_busy);
    int lat, bn;
    pulse(mul, div, a, b);
    wait_rdy(60, lat, bn);
    check({name, "_latency"}, lat, e_lat);
    check({name, "_result"}, data_result, e_res);
    check({name, "_exception"}, data_exception, e_exc);
    if (e_busy >= 0) check({name, "_busy_cycles"}, bn, e_busy);
    repeat (2) @(negedge clock);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($signed($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen0, gap, kind;

    repeat (3) @(negedge clock);
    check("reset_result", data_result, 32'h0);
    check("reset_exception", data_exception, 1'b0);
    check("reset_rdy", data_resultRDY, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    directed("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 32);
    directed("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 33, 32);
    directed("mul_minxmin", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, 32);
    if (HAS_DIV) begin
      directed("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 32);
      directed("div_by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'h0, 1'b1, 33, 32);
      directed("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, 32);
    end else begin
      directed("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b1, 1, 0);
      directed("div_by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'h0, 1'b1, 1, 0);
    end
    directed("both_starts", 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd9, 32'hFFFF_FFEE, 1'b0, 33, 32);

    // Restart 10 cycles after the first start: only the second result is reported.
    seen0 = rdy_seen;
    pulse(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (8) @(negedge clock);
    directed("restart", 1'b1, 1'b0, 32'd6, 32'd5, 32'd30, 1'b0, 33, 32);
    repeat (2) @(negedge clock);
    check("restart_rdy_pulses", rdy_seen - seen0, 1);

    // Reset 15 cycles into a multiply.
    pulse(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0321);
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_result", data_result, 32'h0);
    check("midreset_exception", data_exception, 1'b0);
    check("midreset_rdy", data_resultRDY, 1'b0);
    check("midreset_busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    seen0 = rdy_seen;
    repeat (40) @(negedge clock);
    check("midreset_no_rdy", rdy_seen - seen0, 0);
    directed("mul_2x2", 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 33, 32);

    // Random traffic: completions, aborts, starts in the DONE cycle, and async resets.
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      pulse(kind <= 5 || kind == 9, kind >= 6, rnd_operand(), rnd_operand());
      case ($urandom_range(0, 5))
        0:       gap = $urandom_range(0, 15);
        1:       gap = 31;
        2:       gap = 30;
        default: gap = $urandom_range(32, 38);
      endcase
      repeat (gap) @(negedge clock);
      if ($urandom_range(0, 24) == 0) begin
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
    end
    repeat (40) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
